// File: rtl/button_pulse_gen_if.sv
// Button bundle between the raw switch pins and the flasher control FSM.
// Ports: btn_raw (raw pins in), pulse (press/repeat strobes out), level (debounced levels out).
// master drives btn_raw and observes pulse/level; slave is the conditioning block.
interface button_pulse_gen_if #(
  parameter int NUM_BTN = 3
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] pulse;
  logic [NUM_BTN-1:0] level;

  modport master (output btn_raw, input pulse, input level);
  modport slave  (input btn_raw, output pulse, output level);
endinterface

// File: rtl/button_pulse_gen.sv
// Purpose: push-button conditioner: 2-FF sync, counter debounce, one-cycle press pulse, optional auto-repeat.
// Latency: level and its first pulse rise DEBOUNCE_CYCLES+1 edges after a stable raw change is first sampled.
// Backpressure: none; strobes are fire-and-forget, every channel runs independently every cycle.
// Ports: clk; reset (async, active low); btn_if.slave carries btn_raw in, pulse and level out.
// Channel map (by convention): bit 0 = next, bit 1 = faster, bit 2 = slower.
module button_pulse_gen #(
  parameter int                 NUM_BTN         = 3,
  parameter int                 CNT_W           = 20,
  parameter logic [CNT_W-1:0]   DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [CNT_W-1:0]   REPEAT_DELAY    = 20'd900000,
  parameter logic [CNT_W-1:0]   REPEAT_PERIOD   = 20'd300000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 3'b110
) (
  input  logic                  clk,
  input  logic                  reset,
  button_pulse_gen_if.slave     btn_if
);

  localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_CYCLES - 1'b1;
  localparam logic [CNT_W-1:0] RD_LAST = REPEAT_DELAY - 1'b1;
  localparam logic [CNT_W-1:0] RP_LAST = REPEAT_PERIOD - 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] pulse_q;
  logic [NUM_BTN-1:0] level_nxt;
  logic [NUM_BTN-1:0] db_done;
  logic [CNT_W-1:0]   dcnt  [NUM_BTN];
  logic [CNT_W-1:0]   rcnt  [NUM_BTN];
  state_t             state [NUM_BTN];

  // db_done: this edge completes a full run of disagreeing samples, so level flips now.
  // The FSM keys off level_nxt so the first pulse lands in the same cycle level first reads 1,
  // and a repeat can never coincide with the cycle level drops.
  always_comb begin
    level_nxt = level_q;
    db_done   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_done[i] = (sync2[i] != level_q[i]) && (dcnt[i] == DB_LAST);
      if (db_done[i]) begin
        level_nxt[i] = sync2[i];
      end
    end
  end

  // rcnt holds (cycles since last pulse) - 1, so comparing against DELAY-1 / PERIOD-1
  // puts the next strobe exactly DELAY / PERIOD cycles after the previous one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        dcnt[i]  <= '0;
        rcnt[i]  <= '0;
        state[i] <= IDLE;
      end
    end else begin
      sync1   <= btn_if.btn_raw;
      sync2   <= sync1;
      level_q <= level_nxt;
      for (int i = 0; i < NUM_BTN; i++) begin
        if ((sync2[i] == level_q[i]) || db_done[i]) begin
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end

        pulse_q[i] <= 1'b0;
        case (state[i])
          IDLE: begin
            rcnt[i] <= '0;
            if (level_nxt[i] && !level_q[i]) begin
              pulse_q[i] <= 1'b1;
              state[i]   <= HOLD;
            end
          end
          HOLD: begin
            if (!level_nxt[i]) begin
              rcnt[i]  <= '0;
              state[i] <= IDLE;
            end else if (REPEAT_MASK[i]) begin
              if (rcnt[i] == RD_LAST) begin
                pulse_q[i] <= 1'b1;
                rcnt[i]    <= '0;
                state[i]   <= REPEAT;
              end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (!level_nxt[i]) begin
              rcnt[i]  <= '0;
              state[i] <= IDLE;
            end else if (rcnt[i] == RP_LAST) begin
              pulse_q[i] <= 1'b1;
              rcnt[i]    <= '0;
            end else begin
              rcnt[i] <= rcnt[i] + 1'b1;
            end
          end
          default: begin
            rcnt[i]  <= '0;
            state[i] <= IDLE;
          end
        endcase
      end
    end
  end

  assign btn_if.pulse = pulse_q;
  assign btn_if.level = level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
module tb_button_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int NB = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [2:0] mask_v;

  button_pulse_gen_if #(.NUM_BTN(NB)) bif ();

  button_pulse_gen #(
    .NUM_BTN         (NB),
    .CNT_W           (20),
    .DEBOUNCE_CYCLES (20'd4),
    .REPEAT_DELAY    (20'd10),
    .REPEAT_PERIOD   (20'd3),
    .REPEAT_MASK     (3'b110)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_if (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples per edge; level flips once the last DB synchronised
  // samples (raw taken two edges earlier) all disagree with it. Pulses derive from
  // the age of the current press.
  bit samp    [NB][DB+2];
  bit m_level [NB];
  bit m_pulse [NB];
  int m_age   [NB];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NB; c++) begin
        for (int j = 0; j < DB + 2; j++) samp[c][j] = 1'b0;
        m_level[c] = 1'b0;
        m_pulse[c] = 1'b0;
        m_age[c]   = 0;
      end
    end else begin
      for (int c = 0; c < NB; c++) begin
        bit old_level;
        bit all_diff;
        for (int j = DB + 1; j > 0; j--) samp[c][j] = samp[c][j-1];
        samp[c][0] = bif.btn_raw[c];
        all_diff = 1'b1;
        for (int j = 2; j < DB + 2; j++) begin
          if (samp[c][j] == m_level[c]) all_diff = 1'b0;
        end
        old_level = m_level[c];
        if (all_diff) m_level[c] = ~m_level[c];
        if (m_level[c] && !old_level) begin
          m_age[c]   = 0;
          m_pulse[c] = 1'b1;
        end else if (m_level[c]) begin
          m_age[c]++;
          m_pulse[c] = mask_v[c] && (m_age[c] >= RD) && ((m_age[c] - RD) % RP == 0);
        end else begin
          m_pulse[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < NB; c++) begin
      chk($sformatf("model_level%0d", c), 32'(bif.level[c]), 32'(m_level[c]));
      chk($sformatf("model_pulse%0d", c), 32'(bif.pulse[c]), 32'(m_pulse[c]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run(input int n, input int ch, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (bif.pulse[ch]) pulses++;
    end
  endtask

  initial begin
    int p;
    int dur [NB];
    checks      = 0;
    errors      = 0;
    mask_v      = 3'b110;
    reset       = 1'b0;
    bif.btn_raw = '0;
    step(3);
    chk("reset_level", 32'(bif.level), 32'd0);
    chk("reset_pulse", 32'(bif.pulse), 32'd0);
    reset = 1'b1;
    step(3);

    // 1: held, non-repeating channel
    bif.btn_raw[0] = 1'b1;
    step(5);
    chk("t1_level_pre", 32'(bif.level[0]), 32'd0);
    step(1);
    chk("t1_level_rise", 32'(bif.level[0]), 32'd1);
    chk("t1_pulse", 32'(bif.pulse[0]), 32'd1);
    run(24, 0, p);
    chk("t1_no_repeat", 32'(p), 32'd0);
    bif.btn_raw[0] = 1'b0;
    step(10);

    // 2: glitch shorter than the debounce window
    bif.btn_raw[1] = 1'b1;
    step(3);
    bif.btn_raw[1] = 1'b0;
    begin
      int hits;
      hits = 0;
      repeat (15) begin
        @(negedge clk);
        if (bif.level[1] || bif.pulse[1]) hits++;
      end
      chk("t2_glitch", 32'(hits), 32'd0);
    end

    // 3: auto-repeat timing and release
    bif.btn_raw[2] = 1'b1;
    for (int s = 1; s <= 25; s++) begin
      @(negedge clk);
      chk("t3_pulse", 32'(bif.pulse[2]),
          32'((s == 6) || (s == 16) || (s == 19) || (s == 22) || (s == 25)));
    end
    bif.btn_raw[2] = 1'b0;
    run(5, 2, p);
    chk("t3_release_pulses", 32'(p), 32'd1);
    chk("t3_level_held", 32'(bif.level[2]), 32'd1);
    step(1);
    chk("t3_level_fall", 32'(bif.level[2]), 32'd0);
    chk("t3_no_fall_pulse", 32'(bif.pulse[2]), 32'd0);
    step(10);

    // 4: simultaneous presses
    bif.btn_raw[1] = 1'b1;
    bif.btn_raw[2] = 1'b1;
    step(6);
    chk("t4_both", 32'(bif.pulse), 32'b110);
    step(12);
    bif.btn_raw[1] = 1'b0;
    bif.btn_raw[2] = 1'b0;
    step(10);

    // 5: reset while repeating, button still held
    bif.btn_raw[2] = 1'b1;
    step(18);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_level", 32'(bif.level), 32'd0);
    chk("t5_async_pulse", 32'(bif.pulse), 32'd0);
    step(3);
    reset = 1'b1;
    step(5);
    chk("t5_level_pre", 32'(bif.level[2]), 32'd0);
    step(1);
    chk("t5_pulse_t0", 32'(bif.pulse[2]), 32'd1);
    run(9, 2, p);
    chk("t5_gap", 32'(p), 32'd0);
    step(1);
    chk("t5_repeat", 32'(bif.pulse[2]), 32'd1);
    bif.btn_raw[2] = 1'b0;
    step(10);

    // 6: bouncing contact, then stable
    p = 0;
    for (int s = 0; s < 10; s++) begin
      bif.btn_raw[0] = (s % 2 == 0);
      @(negedge clk);
      if (bif.pulse[0]) p++;
    end
    chk("t6_bounce_pulses", 32'(p), 32'd0);
    bif.btn_raw[0] = 1'b1;
    step(5);
    chk("t6_pre", 32'(bif.pulse[0]), 32'd0);
    step(1);
    chk("t6_pulse", 32'(bif.pulse[0]), 32'd1);
    run(15, 0, p);
    chk("t6_single", 32'(p), 32'd0);
    bif.btn_raw[0] = 1'b0;
    step(10);

    // Random presses, bounces and occasional resets against the model
    for (int c = 0; c < NB; c++) dur[c] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < NB; c++) begin
        if (dur[c] == 0) begin
          bif.btn_raw[c] = 1'($urandom_range(0, 1));
          dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 30);
        end else begin
          dur[c]--;
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b0;
        step(2);
        reset = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
